// File: rtl/ace_txn_controller.sv
// ACE master-side transaction controller: WriteClean / ReadShared / MakeUnique with bounded retry,
// plus a concurrent snoop responder. Define ACE_TIMEOUT_EN to add per-state handshake timeouts.
module ace_txn_controller #(
    parameter int unsigned MAX_RETRY   = 10,
    parameter int unsigned SNOOP_DEPTH = 2,
    parameter int unsigned TIMEOUT     = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic read_req,
    input  logic write_req,
    input  logic invalid_req,
    output logic ace_ready,
    output logic req_error,
    input  logic B_okay,
    input  logic R_okay,
    input  logic snoop_miss,
    input  logic response,
    input  logic response_data,
    output logic write_clean_o,
    output logic read_shared_o,
    output logic make_unique_o,
    output logic read_resp_en,
    output logic ac_enable,
    output logic AW_VALID,
    input  logic AW_READY,
    output logic W_VALID,
    input  logic W_READY,
    input  logic B_VALID,
    output logic B_READY,
    output logic AR_VALID,
    input  logic AR_READY,
    input  logic R_VALID,
    output logic R_READY,
    input  logic AC_VALID,
    output logic AC_READY,
    output logic CR_VALID,
    input  logic CR_READY,
    output logic CD_VALID,
    input  logic CD_READY
);

    localparam int unsigned RetryW = $clog2(MAX_RETRY + 1);
    localparam int unsigned CntW   = $clog2(SNOOP_DEPTH + 1);

    typedef enum logic [2:0] {StIdle, StAw, StW, StB, StAr, StR, StErr} req_state_e;
    typedef enum logic [1:0] {OpWrite, OpRead, OpInval} op_e;
    typedef enum logic [1:0] {SIdle, SLook, SResp} snp_state_e;

    req_state_e        state_q, state_d;
    op_e               op_q, op_d;
    logic [RetryW-1:0] retry_q, retry_d, retry_inc;

    snp_state_e        snp_q, snp_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              cr_pend_q, cr_pend_d;
    logic              cd_pend_q, cd_pend_d;
    logic              ac_hs, snp_done;

`ifdef ACE_TIMEOUT_EN
    localparam int unsigned TimerW = $clog2(TIMEOUT + 1);
    logic [TimerW-1:0] wait_q, wait_d;
    logic              waiting;
    assign waiting = state_q inside {StAw, StW, StB, StAr, StR};
`endif

    assign retry_inc = retry_q + RetryW'(1);

    // ---------------- Request FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            op_q    <= OpRead;
            retry_q <= '0;
`ifdef ACE_TIMEOUT_EN
            wait_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            retry_q <= retry_d;
`ifdef ACE_TIMEOUT_EN
            wait_q  <= wait_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        retry_d = retry_q;
        unique case (state_q)
            StIdle: begin
                if (write_req) begin
                    state_d = StAw;
                    op_d    = OpWrite;
                end else if (read_req) begin
                    state_d = StAr;
                    op_d    = OpRead;
                end else if (invalid_req) begin
                    state_d = StAr;
                    op_d    = OpInval;
                end
            end
            StAw: if (AW_READY) state_d = StW;
            StW:  if (W_READY) state_d = StB;
            StB: begin
                if (B_VALID) begin
                    retry_d = retry_inc;
                    if (B_okay)                                state_d = StIdle;
                    else if (retry_inc == RetryW'(MAX_RETRY)) state_d = StErr;
                    else                                       state_d = StAw;
                end
            end
            StAr: if (AR_READY) state_d = StR;
            StR: begin
                if (R_VALID) begin
                    retry_d = retry_inc;
                    if (R_okay)                                state_d = StIdle;
                    else if (retry_inc == RetryW'(MAX_RETRY)) state_d = StErr;
                    else                                       state_d = StAr;
                end
            end
            StErr:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
`ifdef ACE_TIMEOUT_EN
        // Counter value k means k+1 cycles spent waiting in this state.
        if (waiting && state_d == state_q && wait_q == TimerW'(TIMEOUT - 1)) state_d = StErr;
        wait_d = (state_d != state_q || !waiting) ? '0 : wait_q + TimerW'(1);
`endif
        if (state_d == StIdle) retry_d = '0;
    end

    always_comb begin
        ace_ready     = (state_q == StIdle);
        AW_VALID      = (state_q == StAw);
        W_VALID       = (state_q == StW);
        B_READY       = (state_q == StB);
        AR_VALID      = (state_q == StAr);
        R_READY       = (state_q == StR);
        req_error     = (state_q == StErr);
        write_clean_o = (state_q == StAw) || (state_q == StW) || (state_q == StB);
        read_shared_o = ((state_q == StAr) || (state_q == StR)) && (op_q == OpRead);
        make_unique_o = ((state_q == StAr) || (state_q == StR)) && (op_q == OpInval);
        read_resp_en  = (state_q == StR) && R_VALID && R_okay && (op_q == OpRead);
    end

    // ---------------- Snoop FSM ----------------
    assign ac_hs = AC_VALID && AC_READY;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snp_q     <= SIdle;
            cnt_q     <= '0;
            cr_pend_q <= 1'b0;
            cd_pend_q <= 1'b0;
        end else begin
            snp_q     <= snp_d;
            cnt_q     <= cnt_d;
            cr_pend_q <= cr_pend_d;
            cd_pend_q <= cd_pend_d;
        end
    end

    always_comb begin
        snp_d     = snp_q;
        cr_pend_d = cr_pend_q;
        cd_pend_d = cd_pend_q;
        snp_done  = 1'b0;
        unique case (snp_q)
            SIdle: if (cnt_q != '0) snp_d = SLook;
            SLook: begin
                if (response_data) begin
                    cr_pend_d = 1'b1;
                    cd_pend_d = 1'b1;
                    snp_d     = SResp;
                end else if (snoop_miss || response) begin
                    cr_pend_d = 1'b1;
                    snp_d     = SResp;
                end
            end
            SResp: begin
                if (CR_READY) cr_pend_d = 1'b0;
                if (CD_READY) cd_pend_d = 1'b0;
                if (!cr_pend_d && !cd_pend_d) begin
                    snp_done = 1'b1;
                    snp_d    = SIdle;
                end
            end
            default: snp_d = SIdle;
        endcase
        unique case ({ac_hs, snp_done})
            2'b10:   cnt_d = cnt_q + CntW'(1);
            2'b01:   cnt_d = cnt_q - CntW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_comb begin
        AC_READY  = (cnt_q < CntW'(SNOOP_DEPTH));
        ac_enable = (snp_q == SIdle) && (cnt_q != '0);
        CR_VALID  = (snp_q == SResp) && cr_pend_q;
        CD_VALID  = (snp_q == SResp) && cd_pend_q;
    end

endmodule

// File: tb/tb_ace_txn_controller.sv
// Directed scoreboard bench for ace_txn_controller (default build, MAX_RETRY=10, SNOOP_DEPTH=2).
module tb_ace_txn_controller;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic read_req = 1'b0, write_req = 1'b0, invalid_req = 1'b0;
    logic ace_ready, req_error;
    logic B_okay = 1'b0, R_okay = 1'b0;
    logic snoop_miss = 1'b0, response = 1'b0, response_data = 1'b0;
    logic write_clean_o, read_shared_o, make_unique_o, read_resp_en, ac_enable;
    logic AW_VALID, AW_READY = 1'b0, W_VALID, W_READY = 1'b0, B_VALID = 1'b0, B_READY;
    logic AR_VALID, AR_READY = 1'b0, R_VALID = 1'b0, R_READY;
    logic AC_VALID = 1'b0, AC_READY, CR_VALID, CR_READY = 1'b0, CD_VALID, CD_READY = 1'b0;

    ace_txn_controller #(
        .MAX_RETRY  (10),
        .SNOOP_DEPTH(2),
        .TIMEOUT    (64)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .read_req     (read_req),
        .write_req    (write_req),
        .invalid_req  (invalid_req),
        .ace_ready    (ace_ready),
        .req_error    (req_error),
        .B_okay       (B_okay),
        .R_okay       (R_okay),
        .snoop_miss   (snoop_miss),
        .response     (response),
        .response_data(response_data),
        .write_clean_o(write_clean_o),
        .read_shared_o(read_shared_o),
        .make_unique_o(make_unique_o),
        .read_resp_en (read_resp_en),
        .ac_enable    (ac_enable),
        .AW_VALID     (AW_VALID),
        .AW_READY     (AW_READY),
        .W_VALID      (W_VALID),
        .W_READY      (W_READY),
        .B_VALID      (B_VALID),
        .B_READY      (B_READY),
        .AR_VALID     (AR_VALID),
        .AR_READY     (AR_READY),
        .R_VALID      (R_VALID),
        .R_READY      (R_READY),
        .AC_VALID     (AC_VALID),
        .AC_READY     (AC_READY),
        .CR_VALID     (CR_VALID),
        .CR_READY     (CR_READY),
        .CD_VALID     (CD_VALID),
        .CD_READY     (CD_READY)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int b_ok_at = 0;
    int r_ok_at = 0;
    int k;

    typedef struct {
        string tag;
        int    val;
    } exp_t;
    exp_t sb[$];

    // Activity observed on the half cycle before each rising edge.
    int aw_hs, w_hs, b_hs, ar_hs, r_hs, ac_hs, cr_hs, cd_hs;
    int resp_pulses, err_pulses, acen_pulses, wc_cyc, rs_cyc, mu_cyc;

    always @(negedge clk) begin
        if (rst_n) begin
            if (AW_VALID && AW_READY) aw_hs++;
            if (W_VALID && W_READY)   w_hs++;
            if (B_VALID && B_READY)   b_hs++;
            if (AR_VALID && AR_READY) ar_hs++;
            if (R_VALID && R_READY)   r_hs++;
            if (AC_VALID && AC_READY) ac_hs++;
            if (CR_VALID && CR_READY) cr_hs++;
            if (CD_VALID && CD_READY) cd_hs++;
            if (read_resp_en)  resp_pulses++;
            if (req_error)     err_pulses++;
            if (ac_enable)     acen_pulses++;
            if (write_clean_o) wc_cyc++;
            if (read_shared_o) rs_cyc++;
            if (make_unique_o) mu_cyc++;
        end
    end

    task automatic clr();
        aw_hs = 0; w_hs = 0; b_hs = 0; ar_hs = 0; r_hs = 0; ac_hs = 0; cr_hs = 0; cd_hs = 0;
        resp_pulses = 0; err_pulses = 0; acen_pulses = 0; wc_cyc = 0; rs_cyc = 0; mu_cyc = 0;
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic push(input string tag, input int val);
        sb.push_back('{tag, val});
    endtask

    task automatic pop_cmp(input int obs);
        exp_t e;
        if (sb.size() == 0) begin
            n_bad++;
            $error("FAIL sb_empty: observed %0d expected <none queued>", obs);
        end else begin
            e = sb.pop_front();
            check(e.tag, obs, e.val);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Steps until ace_ready returns; k = edges since the request edge (request edge is 1).
    task automatic run_until_ready(input int max_cyc, output int kk);
        kk = 0;
        do begin
            B_okay = (b_hs >= b_ok_at);
            R_okay = (r_hs >= r_ok_at);
            step();
            kk++;
            if (kk == 1) begin
                write_req = 1'b0; read_req = 1'b0; invalid_req = 1'b0;
            end
        end while (!ace_ready && kk < max_cyc);
    endtask

    initial begin
        clr();
        // Reset state
        step(); step();
        check("rst_ace_ready", ace_ready, 1);
        check("rst_ac_ready", AC_READY, 1);
        check("rst_aw_valid", AW_VALID, 0);
        check("rst_w_valid", W_VALID, 0);
        check("rst_b_ready", B_READY, 0);
        check("rst_ar_valid", AR_VALID, 0);
        check("rst_r_ready", R_READY, 0);
        check("rst_cr_cd_valid", {30'd0, CR_VALID, CD_VALID}, 0);
        check("rst_misc_out", {27'd0, req_error, ac_enable, write_clean_o, read_shared_o,
                               make_unique_o}, 0);
        check("rst_resp_en", read_resp_en, 0);
        rst_n = 1'b1;
        step();

        AW_READY = 1'b1; W_READY = 1'b1; B_VALID = 1'b1; AR_READY = 1'b1; R_VALID = 1'b1;

        // Write beats read when both requested
        clr(); b_ok_at = 0; r_ok_at = 0;
        push("wr_aw_hs", 1); push("wr_w_hs", 1); push("wr_b_hs", 1); push("wr_ar_hs", 0);
        push("wr_wc_cycles", 3); push("wr_rs_cycles", 0); push("wr_ready_cycle", 4);
        write_req = 1'b1; read_req = 1'b1;
        run_until_ready(50, k);
        pop_cmp(aw_hs); pop_cmp(w_hs); pop_cmp(b_hs); pop_cmp(ar_hs);
        pop_cmp(wc_cyc); pop_cmp(rs_cyc); pop_cmp(k);

        // Write with one retried response
        clr(); b_ok_at = 1;
        push("wrr_aw_hs", 2); push("wrr_b_hs", 2); push("wrr_err", 0); push("wrr_cycle", 7);
        write_req = 1'b1;
        run_until_ready(50, k);
        pop_cmp(aw_hs); pop_cmp(b_hs); pop_cmp(err_pulses); pop_cmp(k);

        // ReadShared OKAY on the final allowed attempt
        clr(); r_ok_at = 9;
        push("rd_ar_hs", 10); push("rd_r_hs", 10); push("rd_resp_en", 1); push("rd_err", 0);
        push("rd_rs_cycles", 20); push("rd_cycle", 21);
        read_req = 1'b1;
        run_until_ready(100, k);
        pop_cmp(ar_hs); pop_cmp(r_hs); pop_cmp(resp_pulses); pop_cmp(err_pulses);
        pop_cmp(rs_cyc); pop_cmp(k);

        // MakeUnique exhausting retries
        clr(); r_ok_at = 1000;
        push("inv_ar_hs", 10); push("inv_r_hs", 10); push("inv_resp_en", 0); push("inv_err", 1);
        push("inv_mu_cycles", 20); push("inv_cycle", 22);
        invalid_req = 1'b1;
        run_until_ready(100, k);
        pop_cmp(ar_hs); pop_cmp(r_hs); pop_cmp(resp_pulses); pop_cmp(err_pulses);
        pop_cmp(mu_cyc); pop_cmp(k);

        // Read beats invalid
        clr(); r_ok_at = 0;
        push("pri_rs_cycles", 2); push("pri_mu_cycles", 0); push("pri_resp_en", 1);
        read_req = 1'b1; invalid_req = 1'b1;
        run_until_ready(50, k);
        pop_cmp(rs_cyc); pop_cmp(mu_cyc); pop_cmp(resp_pulses);

        // Snoops: depth 2 fills, third waits until a completion frees a slot
        clr(); CR_READY = 1'b0; CD_READY = 1'b1; AC_VALID = 1'b1;
        step(); step(); step();
        check("snp_two_accepts", ac_hs, 2);
        check("snp_ac_ready_full", AC_READY, 0);
        response_data = 1'b1;
        step();
        response_data = 1'b0;
        check("snp_cr_valid_data", CR_VALID, 1);
        check("snp_cd_valid_data", CD_VALID, 1);
        step();
        check("snp_cd_dropped", CD_VALID, 0);
        check("snp_cr_held", CR_VALID, 1);
        check("snp_third_waiting", ac_hs, 2);
        push("snp_third_accept", 3);
        CR_READY = 1'b1; snoop_miss = 1'b1;
        k = 0;
        do begin
            step();
            k++;
        end while (ac_hs < 3 && k < 20);
        AC_VALID = 1'b0;
        pop_cmp(ac_hs);
        push("snp_ac_enable", 3); push("snp_cr_hs", 3); push("snp_cd_hs", 1);
        push("snp_ac_ready_end", 1);
        for (int i = 0; i < 20; i++) step();
        snoop_miss = 1'b0;
        pop_cmp(acen_pulses); pop_cmp(cr_hs); pop_cmp(cd_hs); pop_cmp(AC_READY);

        // Asynchronous reset mid-transaction drops VALID immediately
        AW_READY = 1'b0;
        write_req = 1'b1;
        step();
        write_req = 1'b0;
        step();
        check("arst_aw_before", AW_VALID, 1);
        rst_n = 1'b0;
        #1;
        check("arst_aw_valid", AW_VALID, 0);
        check("arst_ace_ready", ace_ready, 1);
        step();
        rst_n = 1'b1;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ace_txn_controller.md
Name: ace_txn_controller

Overview:
- Parametrised ACE master-side controller between the cache datapath and the coherent interconnect.
- Issues WriteClean on AW/W/B, and ReadShared or MakeUnique on AR/R.
- Retries non-OKAY responses up to a bounded count, then reports an error.
- Services snoops on AC/CR/CD through an independent FSM that can queue up to SNOOP_DEPTH accepted snoops.

Parameters:
MAX_RETRY, 10, attempts per request (first issue included) before req_error; >=1
SNOOP_DEPTH, 2, max accepted-but-uncompleted snoops; >=1
TIMEOUT, 64, wait-cycle limit per handshake state (used only with ACE_TIMEOUT_EN)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
read_req / write_req / invalid_req  in  1 each  datapath requests, sampled only while ace_ready=1
ace_ready  out  1  request FSM idle
req_error  out  1  one-cycle pulse: retries exhausted or timeout
B_okay / R_okay  in  1 each  response status, valid with B_VALID / R_VALID
snoop_miss / response / response_data  in  1 each  datapath snoop lookup result, one-hot
write_clean_o / read_shared_o / make_unique_o  out  1 each  high for the whole transaction
read_resp_en  out  1  one-cycle pulse on OKAY ReadShared completion
ac_enable  out  1  one-cycle pulse when a snoop is dispatched to the datapath
AW_VALID out, AW_READY in; W_VALID out, W_READY in; B_VALID in, B_READY out  1 each
AR_VALID out, AR_READY in; R_VALID in, R_READY out  1 each
AC_VALID in, AC_READY out; CR_VALID out, CR_READY in; CD_VALID out, CD_READY in  1 each

Behaviour:
- Reset: all outputs are Moore decodes of state/count registers.
  - ace_ready=1, AC_READY=1.
  - All other outputs 0; retry counter 0, snoop count 0.
  - Reset mid-transaction drops all VALIDs/READYs asynchronously.
- Request FSM states: IDLE, AW, W, B, AR, R, ERR.
- IDLE: ace_ready=1.
  - Priority when several requests are high: write > read > invalid.
  - The accepted request moves to AW (write) or AR (read/invalid) next cycle; the others are ignored.
- AW: AW_VALID=1 until AW_READY, then W.
- W: W_VALID=1 until W_READY, then B.
- B: B_READY=1 until B_VALID.
  - B_okay=1 -> IDLE.
  - Otherwise retry_cnt+1; if the new count == MAX_RETRY -> ERR, else re-enter AW.
- AR: AR_VALID=1 until AR_READY, then R.
- R: R_READY=1 until R_VALID.
  - R_okay=1 -> IDLE; read_resp_en pulses in the same cycle, for ReadShared only.
  - Otherwise retry as in B, re-entering AR.
- ERR: req_error=1 for one cycle -> IDLE.
- retry_cnt clears on every IDLE entry.
- Single-cycle handshakes: VALID is high the cycle after entry and drops the cycle after READY is seen. Minimum write latency is 3 cycles AW->B; minimum read latency is 2 cycles.
- Snoop count register: incremented on AC handshake (AC_VALID & AC_READY) and decremented on snoop completion; simultaneous increment and decrement leaves it unchanged. AC_READY = (count < SNOOP_DEPTH).
- Snoop FSM states: SIDLE, LOOK, RESP.
  - SIDLE: if count>0 -> LOOK; ac_enable pulses on that transition.
  - LOOK: wait for one of snoop_miss/response/response_data.
    - snoop_miss or response: CR_VALID=1.
    - response_data: CR_VALID=1 and CD_VALID=1 together.
  - RESP: each VALID drops independently the cycle after its READY. When all raised VALIDs have completed, the snoop completes and the FSM returns to SIDLE.
- The snoop FSM runs fully concurrently with the request FSM; no arbitration between them.

Optional Feature:
- Macro ACE_TIMEOUT_EN.
- Defined: a wait counter resets on every state entry and increments in AW, W, B, AR, R. When it reaches TIMEOUT, the FSM goes to ERR, the VALID drops and req_error pulses; the snoop FSM is unaffected.
- Undefined: no counter; the FSM waits indefinitely and TIMEOUT is unused.

Test Plan:
- Reset, hold all inputs 0 -> ace_ready=1, AC_READY=1, all other outputs 0.
- write_req and read_req pulsed together, all READYs=1, B_okay=1 -> write_clean_o high, AW/W/B each handshake once, ace_ready back at cycle 4, read ignored.
- read_req; R_okay=0 on attempts 1-9, 1 on attempt 10 -> nine re-issued ARs, read_resp_en pulse once, no req_error.
- invalid_req; R_okay=0 for 10 attempts -> req_error pulse after 10th R handshake, make_unique_o falls, read_resp_en never asserted.
- Three back-to-back AC_VALID with SNOOP_DEPTH=2, CR_READY held 0 -> AC_READY falls after 2 accepts, third waits; response_data -> CR_VALID and CD_VALID together; releasing CR_READY lets the third accept.
- ACE_TIMEOUT_EN, TIMEOUT=64, write_req with AW_READY stuck 0 -> AW_VALID high 64 cycles, req_error pulse, then ace_ready=1.
